dmem_responder: RTL and testbench

- Multi-cycle data-memory responder. It is the memory-side end of the CPU data-access interface.
- Accepts one load/store request at a time from the 16-bit CPU and services it against an internal word array after a programmable number of wait states.
- Returns a one-cycle acknowledge, plus read data for loads.
- Replaces the single-cycle data memory when the CPU runs with a request/acknowledge data port.

---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, WAIT wait states, one-cycle ack.
// Define DMEM_FAULT_EN to flag misaligned/out-of-range requests on fault instead of aliasing.
module dmem_responder #(
  parameter int unsigned AW   = 6,
  parameter int unsigned WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter runs WAIT+1 down to 1 so the response edge lands WAIT+1 edges after acceptance.
  localparam logic [4:0] CNT_LOAD = 5'(WAIT + 1);

  logic [1:0]    r_state;
  logic [4:0]    r_cnt;
  logic          r_we;
  logic [AW-1:0] r_widx;
  logic [15:0]   r_wdata;
  logic          r_flt;
  logic [15:0]   r_rdata;
  logic          r_ack;
  logic          r_fault;
  logic [15:0]   r_mem [2**AW];

  logic          w_accept;
  logic          w_respond;
  logic          w_req_flt;
  logic          w_acc_we;
  logic          w_acc_flt;
  logic [AW-1:0] w_acc_idx;
  logic [15:0]   w_acc_wdata;

`ifdef DMEM_FAULT_EN
  assign w_req_flt = addr[0] | (|addr[15:AW+1]);
`else
  logic w_unused_addr;
  assign w_req_flt     = 1'b0;
  assign w_unused_addr = ^{addr[15:AW+1], addr[0]};
`endif

  assign w_accept  = (r_state == S_IDLE) && req;
  assign w_respond = (w_accept && (WAIT == 0)) || ((r_state == S_WAIT) && (r_cnt == 5'd1));

  // On the zero-wait path the access happens at the acceptance edge, so it uses the live request.
  assign w_acc_we    = (r_state == S_IDLE) ? we          : r_we;
  assign w_acc_flt   = (r_state == S_IDLE) ? w_req_flt   : r_flt;
  assign w_acc_idx   = (r_state == S_IDLE) ? addr[AW:1]  : r_widx;
  assign w_acc_wdata = (r_state == S_IDLE) ? wdata       : r_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_widx  <= '0;
      r_wdata <= '0;
      r_flt   <= 1'b0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_widx  <= addr[AW:1];
            r_wdata <= wdata;
            r_flt   <= w_req_flt;
            r_cnt   <= CNT_LOAD;
            r_state <= (WAIT == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      r_ack   <= w_respond;
      r_fault <= w_respond && w_acc_flt;
      if (w_respond && !w_acc_we && !w_acc_flt) begin
        r_rdata <= r_mem[w_acc_idx];
      end
    end
  end

  // Array is never cleared; the reset gate drops any store that would land while reset is held.
  always_ff @(posedge clk) begin
    if (reset && w_respond && w_acc_we && !w_acc_flt) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign busy  = (r_state != S_IDLE);
  assign fault = r_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT=2 instance for timing/data, WAIT=0 instance for the zero-wait path.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req, we;
  logic [15:0] addr, wdata, rdata;
  logic        ack, busy, fault;
  logic        req0, we0;
  logic [15:0] addr0, wdata0, rdata0;
  logic        ack0, busy0, fault0;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.AW(6), .WAIT(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .fault(fault)
  );

  dmem_responder #(.AW(6), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .fault(fault0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction on the WAIT=2 instance; ack must appear 3 edges after acceptance.
  task automatic xact(input string tag, input logic w, input logic [15:0] a,
                      input logic [15:0] d, output logic f);
    int lat;
    lat = -1;
    f   = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack) begin
        lat = k;
        f   = fault;
        req = 1'b0;
        break;
      end
      check({tag, "_busy_wait"}, 32'(busy), 32'd1);
      @(posedge clk);
    end
    if (lat < 0) req = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_busy_resp"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_ack_width"}, 32'(ack), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic   f;
    int     t, n;
    int     times [3];
    logic [15:0] exp_b2b [3];

    reset = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ack",   32'(ack),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset = 1'b1;

    xact("pre0", 1'b1, 16'h0000, 16'h1111, f);
    xact("pre2", 1'b1, 16'h0002, 16'h2222, f);
    xact("pre4", 1'b1, 16'h0004, 16'h3333, f);
    xact("pre22", 1'b1, 16'h0022, 16'h7777, f);
    xact("pre30", 1'b1, 16'h0030, 16'h0F0F, f);
    check("rdata_hold_store", 32'(rdata), 32'd0);

    xact("st10", 1'b1, 16'h0010, 16'hBEEF, f);
    check("st10_fault", 32'(f), 32'd0);
    xact("ld10", 1'b0, 16'h0010, 16'h0000, f);
    check("ld10_rdata", 32'(rdata), 32'hBEEF);
    repeat (2) @(negedge clk);
    check("rdata_hold_idle", 32'(rdata), 32'hBEEF);

    // Back-to-back loads with req held high.
    exp_b2b[0] = 16'h1111; exp_b2b[1] = 16'h2222; exp_b2b[2] = 16'h3333;
    t = 0; n = 0;
    times[0] = 0; times[1] = 0; times[2] = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0000;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      t++;
      if (ack) begin
        times[n] = t;
        check("b2b_rdata", 32'(rdata), 32'(exp_b2b[n]));
        n++;
        if (n < 3) addr = 16'(2 * n);
        else req = 1'b0;
      end
    end
    req = 1'b0;
    check("b2b_count", 32'(n), 32'd3);
    check("b2b_first", 32'(times[0]), 32'd4);
    check("b2b_gap1", 32'(times[1] - times[0]), 32'd5);
    check("b2b_gap2", 32'(times[2] - times[1]), 32'd5);
    repeat (2) @(negedge clk);

    // Inputs change and req drops during WAIT; captured values must win.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; addr = 16'h0022; wdata = 16'h5555;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (ack) begin n = 1; break; end
      @(negedge clk);
    end
    check("midwait_ack", 32'(n), 32'd1);
    @(negedge clk);
    xact("ld20", 1'b0, 16'h0020, 16'h0000, f);
    check("midwait_20", 32'(rdata), 32'hAAAA);
    xact("ld22", 1'b0, 16'h0022, 16'h0000, f);
    check("midwait_22", 32'(rdata), 32'h7777);

    // Reset one cycle after accepting a store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'h1234;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    req = 1'b0;
    #1;
    check("rstmid_ack",   32'(ack),   32'd0);
    check("rstmid_busy",  32'(busy),  32'd0);
    check("rstmid_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    xact("ld30", 1'b0, 16'h0030, 16'h0000, f);
    check("rstmid_30", 32'(rdata), 32'h0F0F);

    // Zero-wait instance: ack and busy in the cycle right after acceptance only.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0002; wdata0 = 16'h4444;
    @(posedge clk);
    @(negedge clk);
    check("w0_st_ack",  32'(ack0),  32'd1);
    check("w0_st_busy", 32'(busy0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("w0_st_ack_end",  32'(ack0),  32'd0);
    check("w0_st_busy_end", 32'(busy0), 32'd0);
    req0 = 1'b1; we0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w0_ld_ack",   32'(ack0),   32'd1);
    check("w0_ld_busy",  32'(busy0),  32'd1);
    check("w0_ld_rdata", 32'(rdata0), 32'h4444);
    req0 = 1'b0;
    @(negedge clk);
    check("w0_ld_busy_end", 32'(busy0), 32'd0);
    check("w0_fault", 32'(fault0), 32'd0);

    // Misaligned and out-of-range stores.
    xact("st11", 1'b1, 16'h0011, 16'h6666, f);
`ifdef DMEM_FAULT_EN
    check("st11_fault", 32'(f), 32'd1);
`else
    check("st11_fault", 32'(f), 32'd0);
`endif
    xact("st100", 1'b1, 16'h0100, 16'h9999, f);
`ifdef DMEM_FAULT_EN
    check("st100_fault", 32'(f), 32'd1);
`else
    check("st100_fault", 32'(f), 32'd0);
`endif
    xact("ld10b", 1'b0, 16'h0010, 16'h0000, f);
`ifdef DMEM_FAULT_EN
    check("flt_10", 32'(rdata), 32'hBEEF);
`else
    check("alias_10", 32'(rdata), 32'h6666);
`endif
    xact("ld0", 1'b0, 16'h0000, 16'h0000, f);
`ifdef DMEM_FAULT_EN
    check("flt_0", 32'(rdata), 32'h1111);
`else
    check("alias_0", 32'(rdata), 32'h9999);
`endif
    check("ld0_fault", 32'(f), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
